// File: rtl/preamble_serial_tx.sv
// -----------------------------------------------------------------------------
// preamble_serial_tx
//
// Transmit end of the 16-bit sequence-gated data path. A parallel word is
// accepted over a valid/ready handshake and sent on a single serial wire as a
// frame: PRE_W preamble bits (PREAMBLE, MSB first) followed by the DATA_W-bit
// payload, MSB first. The far end detects the preamble to arm its capture.
//
// Optional feature (compile-time macro PREAMBLE_TX_PARITY_EN):
//   defined   - one even-parity bit (XOR of the captured word) follows the
//               payload, done moves to that parity cycle, frame is 21 bits.
//   undefined - no parity state, done falls on the last data bit, frame is
//               20 bits.
//
// Ports:
//   clk         in   1       single clock, all state updates on rising edge
//   reset       in   1       synchronous, active-high reset
//   data_in     in   DATA_W  word to transmit, sampled only on handshake
//   valid_in    in   1       data_in holds a word to send
//   ready_out   out  1       block can accept a word (IDLE), reset value 1
//   serial_out  out  1       registered serial line, idle level 0
//   busy        out  1       frame in progress
//   frame_start out  1       one-cycle pulse on the first preamble bit
//   done        out  1       one-cycle pulse on the last bit of the frame
//
// Every output is a flop loaded from the next-state decode, so each output
// shows the bit belonging to the state entered at that edge and there is no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module preamble_serial_tx #(
  parameter int unsigned      DATA_W   = 16,
  parameter int unsigned      PRE_W    = 4,
  parameter logic [PRE_W-1:0] PREAMBLE = 4'b1010
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              serial_out,
  output logic              busy,
  output logic              frame_start,
  output logic              done
);

  // Bit counter must reach max(PRE_W, DATA_W)-1.
  localparam int unsigned      CNT_W    = 5;
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2
`ifdef PREAMBLE_TX_PARITY_EN
    ,
    S_PARITY   = 2'd3
`endif
  } state_t;

  // Preamble bit for a given counter value, MSB first. A shift avoids a
  // variable bit-select into the parameter.
  function automatic logic preamble_bit(input logic [CNT_W-1:0] idx);
    logic [PRE_W-1:0] shifted;
    shifted = PREAMBLE << idx;
    return shifted[PRE_W-1];
  endfunction

`ifdef PREAMBLE_TX_PARITY_EN
  // Even parity: the bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction
`endif

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic [DATA_W-1:0]   shreg_r;
  logic [DATA_W-1:0]   shreg_nxt_s;
`ifdef PREAMBLE_TX_PARITY_EN
  logic                parity_r;
  logic                parity_nxt_s;
`endif

  logic                ready_r;
  logic                serial_r;
  logic                busy_r;
  logic                frame_start_r;
  logic                done_r;

  logic                serial_nxt_s;
  logic                frame_start_nxt_s;
  logic                done_nxt_s;

  // Next-state, counter and shift-register decode.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    shreg_nxt_s  = shreg_r;
`ifdef PREAMBLE_TX_PARITY_EN
    parity_nxt_s = parity_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (valid_in && ready_r) begin
          state_nxt_s  = S_PREAMBLE;
          cnt_nxt_s    = 5'd0;
          shreg_nxt_s  = data_in;
`ifdef PREAMBLE_TX_PARITY_EN
          parity_nxt_s = even_parity(data_in);
`endif
        end else begin
          cnt_nxt_s    = 5'd0;
        end
      end
      S_PREAMBLE: begin
        if (cnt_r == PRE_LAST) begin
          // Shift register is left untouched so the first data cycle
          // presents the word MSB.
          state_nxt_s = S_DATA;
          cnt_nxt_s   = 5'd0;
        end else begin
          cnt_nxt_s   = cnt_r + 5'd1;
        end
      end
      S_DATA: begin
        shreg_nxt_s = shreg_r << 1;
        if (cnt_r == DATA_LAST) begin
`ifdef PREAMBLE_TX_PARITY_EN
          state_nxt_s = S_PARITY;
`else
          state_nxt_s = S_IDLE;
`endif
          cnt_nxt_s   = 5'd0;
        end else begin
          cnt_nxt_s   = cnt_r + 5'd1;
        end
      end
`ifdef PREAMBLE_TX_PARITY_EN
      S_PARITY: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = 5'd0;
      end
`endif
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = 5'd0;
      end
    endcase
  end

  // Output decode from the state about to be entered; feeds the output flops.
  always_comb begin
    serial_nxt_s      = 1'b0;
    frame_start_nxt_s = 1'b0;
    done_nxt_s        = 1'b0;
    case (state_nxt_s)
      S_IDLE: begin
        serial_nxt_s = 1'b0;
      end
      S_PREAMBLE: begin
        serial_nxt_s      = preamble_bit(cnt_nxt_s);
        frame_start_nxt_s = (cnt_nxt_s == 5'd0);
      end
      S_DATA: begin
        serial_nxt_s = shreg_nxt_s[DATA_W-1];
`ifdef PREAMBLE_TX_PARITY_EN
        done_nxt_s   = 1'b0;
`else
        done_nxt_s   = (cnt_nxt_s == DATA_LAST);
`endif
      end
`ifdef PREAMBLE_TX_PARITY_EN
      S_PARITY: begin
        serial_nxt_s = parity_nxt_s;
        done_nxt_s   = 1'b1;
      end
`endif
      default: begin
        serial_nxt_s = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs; reset drops any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_IDLE;
      cnt_r         <= 5'd0;
      shreg_r       <= '0;
`ifdef PREAMBLE_TX_PARITY_EN
      parity_r      <= 1'b0;
`endif
      ready_r       <= 1'b1;
      serial_r      <= 1'b0;
      busy_r        <= 1'b0;
      frame_start_r <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      shreg_r       <= shreg_nxt_s;
`ifdef PREAMBLE_TX_PARITY_EN
      parity_r      <= parity_nxt_s;
`endif
      ready_r       <= (state_nxt_s == S_IDLE);
      serial_r      <= serial_nxt_s;
      busy_r        <= (state_nxt_s != S_IDLE);
      frame_start_r <= frame_start_nxt_s;
      done_r        <= done_nxt_s;
    end
  end

  assign ready_out   = ready_r;
  assign serial_out  = serial_r;
  assign busy        = busy_r;
  assign frame_start = frame_start_r;
  assign done        = done_r;

endmodule

// File: tb/tb_preamble_serial_tx.sv
`timescale 1ns/1ps

module tb_preamble_serial_tx;

`ifdef PREAMBLE_TX_PARITY_EN
  localparam int FLEN = 21;
`else
  localparam int FLEN = 20;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic        serial_out;
  logic        busy;
  logic        frame_start;
  logic        done;

  int checks;
  int failures;

  preamble_serial_tx dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .serial_out  (serial_out),
    .busy        (busy),
    .frame_start (frame_start),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle: {ready_out, serial_out, busy, frame_start, done}
  localparam logic [4:0] IDLE_OUTS = 5'b10000;

  typedef struct {
    logic [15:0] data;       // word offered at the handshake
    logic [15:0] exp_word;   // payload expected on the line
    int          chg_k;      // frame cycle at which data_in is changed (-1: never)
    logic [15:0] chg_data;   // value driven at chg_k
    logic        exp_par;    // hand-computed even parity of exp_word
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {rdy,ser,busy,fs,done}=%b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {ready_out, serial_out, busy, frame_start, done};
  endfunction

  // Called in the first cycle after the handshake edge; checks every frame
  // cycle and leaves the bench in the cycle after done (checked as idle).
  task automatic check_frame(input logic [15:0] exp_word, input logic exp_par,
                             input int chg_k, input logic [15:0] chg_data,
                             input string tag);
    logic [3:0] pre_bits;
    logic       bit_e;
    pre_bits = 4'b1010;
    for (int k = 0; k < FLEN; k++) begin
      if (k < 4)       bit_e = pre_bits[3-k];
      else if (k < 20) bit_e = exp_word[19-k];
      else             bit_e = exp_par;
      chk($sformatf("%s bit%0d", tag, k + 1), outs(),
          {1'b0, bit_e, 1'b1, (k == 0), (k == FLEN - 1)});
      if (k == chg_k) data_in = chg_data;
      tick();
    end
    chk($sformatf("%s idle after done", tag), outs(), IDLE_OUTS);
  endtask

  initial begin
    int done_seen;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 16'h0000;

    vecs[0] = '{16'hA5C3, 16'hA5C3, -1, 16'h0000, 1'b0};
    vecs[1] = '{16'h0001, 16'h0001, -1, 16'h0000, 1'b1};
    vecs[2] = '{16'hA5C3, 16'hA5C3,  7, 16'h1234, 1'b0};  // change at frame cycle 8
    vecs[3] = '{16'h8000, 16'h8000, -1, 16'h0000, 1'b1};

    tick();
    tick();
    reset = 1'b0;

    // Idle with no valid_in for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("idle%0d", i), outs(), IDLE_OUTS);
      tick();
    end

    // Table-driven single frames.
    for (int v = 0; v < 4; v++) begin
      data_in  = vecs[v].data;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      check_frame(vecs[v].exp_word, vecs[v].exp_par, vecs[v].chg_k,
                  vecs[v].chg_data, $sformatf("vec%0d", v));
      tick();
    end

    // valid_in held high: FFFF then 0000 back to back, one idle cycle between.
    data_in  = 16'hFFFF;
    valid_in = 1'b1;
    tick();
    data_in  = 16'h0000;
    check_frame(16'hFFFF, 1'b0, -1, 16'h0000, "b2b_first");
    tick();
    valid_in = 1'b0;
    check_frame(16'h0000, 1'b0, -1, 16'h0000, "b2b_second");
    tick();
    chk("b2b no third frame", outs(), IDLE_OUTS);

    // Reset in cycle 10 of a frame.
    data_in  = 16'hA5C3;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 9) reset = 1'b1;
      tick();
    end
    reset = 1'b0;
    chk("reset midframe", outs(), IDLE_OUTS);
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (outs() !== IDLE_OUTS) done_seen++;
      tick();
    end
    chk("stays idle after abort", {4'b0000, (done_seen != 0)}, 5'b00000);

    data_in  = 16'h00FF;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    check_frame(16'h00FF, 1'b0, -1, 16'h0000, "after_reset");
    tick();

    // reset and valid_in together: reset wins, no frame starts.
    reset    = 1'b1;
    valid_in = 1'b1;
    data_in  = 16'h5555;
    tick();
    reset    = 1'b0;
    valid_in = 1'b0;
    chk("reset+valid edge", outs(), IDLE_OUTS);
    tick();
    chk("reset+valid no frame", outs(), IDLE_OUTS);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
